spi_counter_rx: RTL and testbench

SPI_COUNTER_RX -- requirements
Module: spi_counter_rx

---
 rtl/spi_counter_pkg.sv | 11 +
 rtl/sync_ff.sv | 25 ++
 rtl/spi_counter_rx.sv | 134 +++++++++++++
 tb/tb_spi_counter_rx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_counter_pkg.sv
// Shared definitions for the SPI counter link: receiver FSM states and word width.
package spi_counter_pkg;
    localparam int DATA_W_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE,
        RX_HIGH,
        RX_LOW,
        WAIT_SS
    } state_t;
endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous input bit.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_counter_rx.sv
// SPI mode-0 slave that receives a 2-byte frame and rebuilds a DATA_W-bit counter word.
module spi_counter_rx
    import spi_counter_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic              miso,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_frame_err
);

    logic sclk_s, mosi_s, ss_s;
    logic sclk_d, ss_d;
    logic strobe, ss_fall;

    state_t state, state_next;

    logic [7:0]        shift_q;
    logic [7:0]        byte_next;
    logic [2:0]        bit_cnt;
    logic [DATA_W-9:0] high_byte;
    logic              last_bit;

    logic clr, shift_en, load_high, complete, abort;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(ss), .q(ss_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            ss_d   <= ss_s;
        end
    end

    assign strobe    = sclk_s & ~sclk_d;
    assign ss_fall   = ss_d & ~ss_s;
    assign byte_next = {shift_q[6:0], mosi_s};
    assign last_bit  = (bit_cnt == 3'd7);
    assign miso      = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        clr        = 1'b0;
        shift_en   = 1'b0;
        load_high  = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = RX_HIGH;
                    clr        = 1'b1;
                end
            end
            RX_HIGH: begin
                if (ss_s) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (strobe) begin
                    shift_en = 1'b1;
                    if (last_bit) begin
                        load_high  = 1'b1;
                        state_next = RX_LOW;
                    end
                end
            end
            RX_LOW: begin
                // The final strobe wins over a simultaneous ss release: the frame is complete.
                if (strobe && last_bit) begin
                    shift_en   = 1'b1;
                    complete   = 1'b1;
                    state_next = WAIT_SS;
                end else if (ss_s) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (strobe) begin
                    shift_en = 1'b1;
                end
            end
            WAIT_SS: begin
                if (ss_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt     <= '0;
            high_byte   <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= complete;
            o_frame_err <= abort;
            if (clr) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shift_q <= byte_next;
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (load_high) high_byte <= byte_next[DATA_W-9:0];
            if (complete)  o_data    <= {high_byte, byte_next};
        end
    end

endmodule

// File: tb/tb_spi_counter_rx.sv
// Scoreboard bench: directed SPI frames push expected events; a monitor pops them on DUT output pulses.
`timescale 1ns/1ps
module tb_spi_counter_rx;
    import spi_counter_pkg::*;

    localparam int DW = DATA_W_DEFAULT;

    logic          clk;
    logic          reset;
    logic          sclk;
    logic          mosi;
    logic          ss;
    logic          miso;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;

    typedef struct {
        logic          is_err;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic miso_bad = 1'b0;

    spi_counter_rx #(.SYNC_STAGES(2), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
        .miso(miso), .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_ev(input logic is_err, input logic [DW-1:0] data);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    // Master BFM: mosi changes in the low phase, DUT samples on the rising edge.
    task automatic pulse(input logic b);
        mosi = b;
        #500 sclk = 1'b1;
        #500 sclk = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) pulse(w[15-i]);
    endtask

    task automatic xfer(input logic [15:0] w);
        ss = 1'b0;
        #500;
        send(w, 16);
        #500 ss = 1'b1;
        #2000;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (miso !== 1'b0) miso_bad = 1'b1;
            if (o_valid && o_frame_err) check("valid_err_exclusive", 1, 0);
            if (o_valid || o_frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {31'd0, o_frame_err}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_kind_err", {31'd0, o_frame_err}, {31'd0, e.is_err});
                    check("event_data", {18'd0, o_data}, {18'd0, e.data});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ss    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        #25;
        check("reset_o_data", {18'd0, o_data}, 0);
        check("reset_o_valid", {31'd0, o_valid}, 0);
        check("reset_o_frame_err", {31'd0, o_frame_err}, 0);
        check("reset_miso", {31'd0, miso}, 0);
        reset = 1'b1;
        #100;

        // V1: 0x0D,0x05 -> 3333
        expect_ev(1'b0, 14'd3333);
        xfer(16'h0D05);

        // V2: back-to-back 0, 1, 9999
        expect_ev(1'b0, 14'd0);
        xfer(16'h0000);
        expect_ev(1'b0, 14'd1);
        xfer(16'h0001);
        expect_ev(1'b0, 14'd9999);
        xfer(16'h270F);

        // V3: good 42, then abort after 5 low-byte bits
        expect_ev(1'b0, 14'd42);
        xfer(16'h002A);
        expect_ev(1'b1, 14'd42);
        ss = 1'b0;
        #500;
        send(16'h1234, 13);
        #500 ss = 1'b1;
        #2000;
        check("abort_keeps_o_data", {18'd0, o_data}, 42);

        // V4: 0xFFFF truncates to 16383; trailing pulses ignored in WAIT_SS
        expect_ev(1'b0, 14'd16383);
        ss = 1'b0;
        #500;
        send(16'hFFFF, 16);
        repeat (4) pulse(1'b1);
        #500 ss = 1'b1;
        #2000;
        check("extra_pulses_o_data", {18'd0, o_data}, 16383);

        // V5: reset after 9 bits, then a fresh full transfer of 7
        ss = 1'b0;
        #500;
        send(16'hA5A5, 9);
        reset = 1'b0;
        ss    = 1'b1;
        #200;
        check("midreset_o_data", {18'd0, o_data}, 0);
        reset = 1'b1;
        #2000;
        expect_ev(1'b0, 14'd7);
        xfer(16'h0007);

        // V6: sclk activity with ss high is ignored
        repeat (20) pulse(1'b1);
        #2000;
        check("idle_sclk_o_data", {18'd0, o_data}, 7);

        check("pending_events", exp_q.size(), 0);
        check("miso_always_zero", {31'd0, miso_bad}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
